dmem_write_buffer: RTL and testbench

- Sits directly downstream of the pipelined CPU's data-memory port (dmemaddr/dmemwdata/dmemwrite/dmemread/dmemrdata) and in front of a slow, handshaked data memory.
- Posts CPU stores into a small FIFO and drains them in the background.
- Serves loads from the youngest matching buffered store; otherwise fetches from memory.
- Raises stall when the CPU must hold its current memory access.

---
 rtl/dmem_write_buffer_if.sv | 33 +++
 rtl/dmem_write_buffer.sv | 171 +++++++++++++++++
 tb/tb_dmem_write_buffer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_write_buffer_if.sv
// dmem_write_buffer_if: CPU data-port and slow-memory handshake bundle for the store buffer.
// Ports: cpu_* (CPU load/store request, load data, stall, buffer-empty flag),
//        mem_* (held request with write/read select, address, write data, ack, read data).
interface dmem_write_buffer_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_write;
  logic          cpu_read;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          wb_empty;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  // Buffer side: consumes CPU requests and memory responses.
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write, cpu_read, mem_ack, mem_rdata,
    output cpu_rdata, stall, wb_empty, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Environment side: the CPU plus the memory.
  modport master (
    output cpu_addr, cpu_wdata, cpu_write, cpu_read, mem_ack, mem_rdata,
    input  cpu_rdata, stall, wb_empty, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posts CPU stores into a DEPTH-entry FIFO, drains them to a slow
// handshaked memory, forwards loads from the youngest buffered store, else fetches.
// Ports: clock, reset (async, active-low), bus (slave modport of dmem_write_buffer_if).
// Latency: load hit 0 cycles; load miss 2 stall cycles minimum; store 0 unless full.
// Backpressure: stall while the buffer is full on a store or until a missed load returns.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_write_buffer_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WREQ, RREQ, RDONE} state_t;

  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cap_q, cap_d;
  logic [DW-1:0] rdata_q;

  logic          is_store, is_load, full, push, pop;
  logic          hit, rd_miss, stall_c;
  logic [DW-1:0] hit_data, rdata_c;
  logic [PW-1:0] idx;

  // A simultaneous read+write request is treated as a store.
  assign is_store = bus.cpu_write;
  assign is_load  = bus.cpu_read & ~bus.cpu_write;
  assign full     = (count_q == CW'(DEPTH));
  assign push     = is_store & ~full;
  assign pop      = (state_q == WREQ) & bus.mem_ack;
  assign rd_miss  = is_load & ~hit;

  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (fifo_addr_q[idx] == bus.cpu_addr)) begin
        hit      = 1'b1;
        hit_data = fifo_data_q[idx];
      end
    end
  end

  assign head_d  = pop  ? head_q + PW'(1) : head_q;
  assign tail_d  = push ? tail_q + PW'(1) : tail_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  // Entry storage needs no reset: validity comes from count/head.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[tail_q] <= bus.cpu_addr;
      fifo_data_q[tail_q] <= bus.cpu_wdata;
    end
  end

  // Next-state logic. A load miss wins over pending stores; a store arriving
  // into an empty buffer starts draining at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_miss)                          state_d = RREQ;
        else if ((count_q != '0) || push)     state_d = WREQ;
      end
      WREQ:    if (bus.mem_ack) state_d = IDLE;
      RREQ:    if (bus.mem_ack) state_d = RDONE;
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered memory-side outputs, loaded on entry to a request state and held
  // until the ack. Entering WREQ from an empty buffer means the head entry is
  // the store being pushed this cycle.
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cap_d       = cap_q;
    case (state_d)
      WREQ: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
        if (state_q != WREQ) begin
          if (count_q != '0) begin
            mem_addr_d  = fifo_addr_q[head_q];
            mem_wdata_d = fifo_data_q[head_q];
          end else begin
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
          end
        end
      end
      RREQ: begin
        mem_req_d = 1'b1;
        if (state_q != RREQ) mem_addr_d = bus.cpu_addr;
      end
      default: ;
    endcase
    if ((state_q == RREQ) && bus.mem_ack) cap_d = bus.mem_rdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cap_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cap_q       <= cap_d;
      rdata_q     <= rdata_c;
    end
  end

  // Load data: fetched word in RDONE, forwarded store on a hit, else hold.
  always_comb begin
    if (state_q == RDONE)     rdata_c = cap_q;
    else if (is_load && hit)  rdata_c = hit_data;
    else                      rdata_c = rdata_q;
  end

  // Full stalls a store on registered count only; a miss stalls until RDONE.
  always_comb begin
    if (is_store)     stall_c = full;
    else if (is_load) stall_c = ~hit & (state_q != RDONE);
    else              stall_c = 1'b0;
  end

  // Stall is forced low while reset is asserted even if a load is presented.
  assign bus.stall     = reset & stall_c;
  assign bus.cpu_rdata = rdata_c;
  assign bus.wb_empty  = (count_q == '0);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer: directed test-plan scenarios plus randomized CPU/memory traffic
// against an architectural memory model and a queue of posted stores.
module tb_dmem_write_buffer;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_write_buffer_if #(.AW(16), .DW(16)) bus ();

  dmem_write_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {logic [15:0] a; logic [15:0] d;} ent_t;

  int checks = 0;
  int errors = 0;

  ent_t        q[$];                 // stores accepted but not yet written to memory
  logic [15:0] phys [logic [15:0]];  // contents of the slow memory
  logic [15:0] arch [logic [15:0]];  // memory as the CPU program sees it
  logic [16:0] tlog[$];              // acked transactions {we, addr}
  logic [15:0] last_data;
  bit          rd_acked, prev_req, prev_ack, prev_we, stall_s;
  int          sc;
  int          n_c;
  bit          hit_c, miss_c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A6A;
  endfunction

  function logic [15:0] phys_rd(input logic [15:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction

  function logic [15:0] arch_rd(input logic [15:0] a);
    return arch.exists(a) ? arch[a] : init_val(a);
  endfunction

  // Compare process: every cycle, judge outputs against the model, then advance it.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_stall", bus.stall, 0);
      chk("rst_wb_empty", bus.wb_empty, 1);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      q.delete();
      arch = phys;
      last_data = '0;
      rd_acked = 0; prev_req = 0; prev_ack = 0; prev_we = 0; stall_s = 0; sc = 0;
    end else begin
      n_c = q.size();
      chk("wb_empty", bus.wb_empty, n_c == 0);
      if (prev_req && !prev_ack) begin
        chk("req_hold", bus.mem_req, 1);
        chk("we_hold", bus.mem_we, prev_we);
      end
      if (bus.mem_req && bus.mem_we) begin
        if (n_c == 0) chk("wr_nonempty", 0, 1);
        else begin
          chk("wr_addr", bus.mem_addr, q[0].a);
          chk("wr_data", bus.mem_wdata, q[0].d);
        end
      end
      hit_c = 0;
      for (int i = 0; i < n_c; i++) if (q[i].a == bus.cpu_addr) hit_c = 1;
      miss_c = bus.cpu_read && !bus.cpu_write && !hit_c;
      if (bus.mem_req && !bus.mem_we) begin
        chk("rd_owner", miss_c, 1);
        chk("rd_addr", bus.mem_addr, bus.cpu_addr);
      end
      if (bus.cpu_write) begin
        chk("st_stall", bus.stall, n_c == DEPTH);
      end else if (bus.cpu_read) begin
        if (hit_c) begin
          chk("hit_stall", bus.stall, 0);
          chk("hit_data", bus.cpu_rdata, arch_rd(bus.cpu_addr));
          last_data = arch_rd(bus.cpu_addr);
        end else begin
          if (rd_acked) chk("rdone_stall", bus.stall, 0);
          if (!bus.stall) begin
            chk("miss_acked", rd_acked, 1);
            chk("miss_data", bus.cpu_rdata, arch_rd(bus.cpu_addr));
            last_data = arch_rd(bus.cpu_addr);
          end
        end
      end else begin
        chk("idle_stall", bus.stall, 0);
        chk("hold_rdata", bus.cpu_rdata, last_data);
      end
      if (bus.stall) sc++; else sc = 0;
      if (sc > 64) begin
        chk("stall_timeout", 0, 1);
        sc = 0;
      end
      if (miss_c && bus.stall) begin
        if (bus.mem_req && !bus.mem_we && bus.mem_ack) rd_acked = 1;
      end else begin
        rd_acked = 0;
      end
      if (bus.mem_req && bus.mem_ack) tlog.push_back({bus.mem_we, bus.mem_addr});
      if (bus.mem_req && bus.mem_we && bus.mem_ack && n_c > 0) begin
        phys[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (bus.cpu_write && n_c < DEPTH) begin
        q.push_back({bus.cpu_addr, bus.cpu_wdata});
        arch[bus.cpu_addr] = bus.cpu_wdata;
      end
      prev_req = bus.mem_req;
      prev_ack = bus.mem_ack;
      prev_we  = bus.mem_we;
      stall_s  = bus.stall;
    end
  end

  // Advance to just after the next rising edge; the memory model presents read data.
  task automatic step();
    @(posedge clock);
    #1;
    bus.mem_rdata = phys_rd(bus.mem_addr);
  endtask

  task automatic drive(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_write = w;
    bus.cpu_read  = r;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 60; k++) if (!ok) begin
      step();
      if (bus.wb_empty && !bus.mem_req) ok = 1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  // Called at +1 after an edge; returns at +3 of the first cycle without stall.
  task automatic wait_unstall(output bit ok);
    ok = 0;
    for (int k = 0; k < 30; k++) if (!ok) begin
      #2;
      if (!bus.stall) ok = 1;
      else step();
    end
  endtask

  initial begin
    bit ok;
    logic [15:0] a16;
    reset = 1'b0;
    drive(0, 0, 16'h0, 16'h0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) step();
    reset = 1'b1;

    // 1: single store drains immediately with ack tied high.
    bus.mem_ack = 1'b1;
    step(); drive(1, 0, 16'h0010, 16'hBEEF); #2;
    chk("t1_stall", bus.stall, 0);
    step(); drive(0, 0, 16'h0, 16'h0); #2;
    chk("t1_req", bus.mem_req, 1);
    chk("t1_we", bus.mem_we, 1);
    chk("t1_addr", bus.mem_addr, 16'h0010);
    chk("t1_wdata", bus.mem_wdata, 16'hBEEF);
    chk("t1_not_empty", bus.wb_empty, 0);
    step(); #2;
    chk("t1_empty", bus.wb_empty, 1);

    // 2: fill to DEPTH, fifth store stalls, accepted one cycle after the first pop.
    bus.mem_ack = 1'b0;
    tlog.delete();
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1, 0, 16'(16'h0100 + i), 16'(16'h1000 + i));
      if (i == 4) bus.mem_ack = 1'b1;
      #2;
      chk("t2_stall", bus.stall, i == 4);
    end
    step(); #2;
    chk("t2_accept", bus.stall, 0);
    step(); drive(0, 0, 16'h0, 16'h0);
    wait_drain();
    chk("t2_nwr", tlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < tlog.size()) chk("t2_order", tlog[i], {1'b1, 16'(16'h0100 + i)});

    // 3: youngest of two stores to one address is forwarded.
    bus.mem_ack = 1'b0;
    step(); drive(1, 0, 16'h0020, 16'h1111);
    step(); drive(1, 0, 16'h0020, 16'h2222);
    step(); drive(0, 1, 16'h0020, 16'h0); #2;
    chk("t3_data", bus.cpu_rdata, 16'h2222);
    chk("t3_stall", bus.stall, 0);
    step(); drive(0, 0, 16'h0, 16'h0);
    bus.mem_ack = 1'b1;
    wait_drain();

    // 4: load miss with memory ack after three request cycles.
    bus.mem_ack = 1'b0;
    step(); drive(0, 1, 16'h0030, 16'h0); #2;
    chk("t4_stall0", bus.stall, 1);
    chk("t4_req0", bus.mem_req, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 3) bus.mem_ack = 1'b1;
      #2;
      chk("t4_stall", bus.stall, 1);
      chk("t4_req", bus.mem_req, 1);
      chk("t4_we", bus.mem_we, 0);
      chk("t4_addr", bus.mem_addr, 16'h0030);
    end
    step(); bus.mem_ack = 1'b0; #2;
    chk("t4_rdone_stall", bus.stall, 0);
    chk("t4_data", bus.cpu_rdata, 16'h5A5A);
    chk("t4_rdone_we", bus.mem_we, 0);
    step(); drive(0, 0, 16'h0, 16'h0);

    // 4b: with ack tied high a miss stalls exactly two cycles.
    bus.mem_ack = 1'b1;
    step(); drive(0, 1, 16'h0031, 16'h0); #2;
    chk("t4b_stall_c0", bus.stall, 1);
    step(); #2;
    chk("t4b_stall_c1", bus.stall, 1);
    step(); #2;
    chk("t4b_stall_c2", bus.stall, 0);
    chk("t4b_data", bus.cpu_rdata, 16'h5A5B);
    step(); drive(0, 0, 16'h0, 16'h0);

    // 5: miss during a drain: drain completes, read next, then remaining store.
    bus.mem_ack = 1'b0;
    tlog.delete();
    step(); drive(1, 0, 16'h0050, 16'hAAAA);
    step(); drive(1, 0, 16'h0051, 16'hBBBB);
    step(); drive(0, 1, 16'h0040, 16'h0); #2;
    chk("t5_stall", bus.stall, 1);
    chk("t5_head", bus.mem_addr, 16'h0050);
    step(); bus.mem_ack = 1'b1;
    wait_unstall(ok);
    chk("t5_done", ok, 1);
    chk("t5_data", bus.cpu_rdata, 16'h5A2A);
    step(); drive(0, 0, 16'h0, 16'h0);
    wait_drain();
    chk("t5_ntx", tlog.size(), 3);
    if (tlog.size() == 3) begin
      chk("t5_tx0", tlog[0], {1'b1, 16'h0050});
      chk("t5_tx1", tlog[1], {1'b0, 16'h0040});
      chk("t5_tx2", tlog[2], {1'b1, 16'h0051});
    end

    // 6: asynchronous reset in the middle of a read request.
    bus.mem_ack = 1'b0;
    step(); drive(1, 0, 16'h0060, 16'hCCCC);
    step(); drive(1, 0, 16'h0061, 16'hDDDD);
    step(); drive(0, 1, 16'h0070, 16'h0);
    step(); bus.mem_ack = 1'b1;
    step(); bus.mem_ack = 1'b0;
    step();
    chk("t6_pre_req", bus.mem_req, 1);
    chk("t6_pre_we", bus.mem_we, 0);
    chk("t6_pre_wb", bus.wb_empty, 0);
    reset = 1'b0;
    #1;
    chk("t6_req", bus.mem_req, 0);
    chk("t6_stall", bus.stall, 0);
    chk("t6_wb", bus.wb_empty, 1);
    drive(0, 0, 16'h0, 16'h0);
    step(); step();
    #1 reset = 1'b1;
    step(); drive(0, 1, 16'h0061, 16'h0); #2;
    chk("t6_miss_stall", bus.stall, 1);
    bus.mem_ack = 1'b1;
    wait_unstall(ok);
    chk("t6_done", ok, 1);
    chk("t6_data", bus.cpu_rdata, 16'h5A0B);
    step(); drive(0, 0, 16'h0, 16'h0);

    // Randomized traffic; a stalled access is held until accepted.
    for (int c = 0; c < 3000; c++) begin
      step();
      bus.mem_ack = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (!stall_s) begin
        a16 = 16'($urandom_range(0, 11));
        case ($urandom_range(0, 9))
          0, 1, 2, 3: drive(1, 0, a16, 16'($urandom));
          4, 5, 6:    drive(0, 1, a16, 16'h0);
          7:          drive(1, 1, a16, 16'($urandom));
          default:    drive(0, 0, a16, 16'h0);
        endcase
      end
    end
    step(); drive(0, 0, 16'h0, 16'h0);
    bus.mem_ack = 1'b1;
    wait_drain();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
